sopc_gpio: RTL
==============

# sopc_gpio

Parametrised memory-mapped GPIO peripheral for the RISC-V SOPC, replacing the fixed 4-key / 4-LED wiring. It synchronises and debounces `KEY_W` active-low push-buttons, drives `LED_W` LED outputs from a register, and raises a level interrupt on enabled key-press (falling) edges. It sits on the SOPC peripheral bus next to the UART and uses the system clock and reset.

## Interface
- `KEY_W`, 4: number of key inputs (1..32).
- `LED_W`, 4: number of LED outputs (1..32).
- `DEB_CYCLES`, 1000000: stable-sample count for a debounced level change (20 ms at 50 MHz); minimum 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `bus_req`  in  1  access request, one-cycle pulse.
- `bus_we`  in  1  1 = write, 0 = read; qualified by `bus_req`.
- `bus_addr`  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; valid while `bus_ack`=1, otherwise 0.
- `bus_ack`  out  1  one-cycle acknowledge.
- `key`  in  KEY_W  raw keys; active-low, idle 1.
- `led`  out  LED_W  LED drive; register value, unmodified.
- `irq`  out  1  interrupt, active high, level.

## Operation
- Register map:
  - 0x0 LED: RW, bits [LED_W-1:0].
  - 0x4 KEY: RO, debounced level.
  - 0x8 IRQ_EN: RW, per-key enable.
  - 0xC IRQ_STAT: sticky press flags; write 1 to clear.
  - Unused upper bits read as 0. Writes to KEY are ignored.
- Synchroniser: two flops per key, both reset to 1.
- Debouncer, per key:
  - The counter clears whenever the synchronised sample equals the debounced state.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1 with a mismatch present, the debounced state takes the sample and the counter clears.
  - Counter width is $clog2(DEB_CYCLES).
- Press detect: a debounced 1→0 transition on key i sets IRQ_STAT[i] on the same clock edge the debounced state updates. Release (0→1) sets nothing.
- A flag sets regardless of IRQ_EN. IRQ_EN masks only `irq`.
- `irq` is a registered output: `irq` = |(IRQ_STAT & IRQ_EN), using the post-update register values.
- Simultaneous W1C and new press on the same bit: the set wins and the bit stays 1.
- Reset values:
  - LED, IRQ_EN, IRQ_STAT = 0.
  - Debounced KEY = all 1; counters = 0.
  - `led`=0, `irq`=0, `bus_ack`=0, `bus_rdata`=0.
- Reset mid-debounce discards the count and returns the key to released (1) with no flag set.

## Timing
- Bus: `bus_req` in cycle N gives `bus_ack`=1 in cycle N+1, for exactly one cycle.
  - Writes take effect at the edge ending cycle N, so `led` updates in N+1.
  - Read data is sampled at the end of cycle N and presented in N+1.
  - Back-to-back requests every cycle are legal.
- Key latency: a pin held stable after a change reaches the KEY register 2+DEB_CYCLES cycles later. IRQ_STAT sets on that same edge, and `irq` rises one cycle after that.
- Glitches shorter than DEB_CYCLES synchronised cycles produce no change.
- IRQ_EN or IRQ_STAT writes affect `irq` one cycle after the write edge.

## Configuration
- Macro `SOPC_GPIO_DEBOUNCE_EN`.
- Defined: the debouncer operates as above.
- Undefined:
  - Debouncers and counters are removed; KEY is the second synchroniser flop directly.
  - Key latency is 2 cycles.
  - Press detect runs on the synchronised signal.
  - `DEB_CYCLES` is ignored.

## Test plan
Bench settings: `DEB_CYCLES`=8, `KEY_W`=`LED_W`=4, 50 MHz clock, macro defined unless stated.
- Reset → `led`=4'h0, `irq`=0. Reading 0x4 returns 0x0000000F; reading 0xC returns 0.
- Write 0xA to 0x0, then read 0x0 → `led`=4'hA from the ack cycle; read returns 0x0000000A; ack occurs 1 cycle after each req.
- Key[1] drops 1→0 and stays low; IRQ_EN=0x2 → KEY reads 0xD exactly 10 cycles after the pin change, IRQ_STAT=0x2, and `irq`=1 one cycle later.
- Key[2] pulses low for 5 cycles → KEY stays 0xF, IRQ_STAT stays 0, `irq` stays 0.
- W1C of 0x2 to 0xC in the same cycle a new key[1] press is debounced → IRQ_STAT[1] stays 1 and `irq` stays 1. A plain W1C of 0x2 afterwards → IRQ_STAT=0 and `irq`=0 next cycle.
- Macro undefined: key[0] falls → KEY reads 0xE 2 cycles later and IRQ_STAT[0] sets on the same edge. Separately, assert `rst_n` low mid-debounce (macro defined) → KEY=0xF, all flags 0 immediately.

Source files
------------

// File: rtl/sopc_gpio.sv
// sopc_gpio: memory-mapped GPIO peripheral for the RISC-V SOPC.
//   Synchronises and (optionally) debounces KEY_W active-low push-buttons,
//   drives LED_W LEDs from a register, and raises a level interrupt on
//   enabled key-press (debounced falling) edges.
//
// Build option:
//   SOPC_GPIO_DEBOUNCE_EN  defined   -> per-key debouncer, KEY latency 2+DEB_CYCLES
//                          undefined -> KEY is the synchroniser output, latency 2,
//                                       DEB_CYCLES is ignored
//
// Register map (byte address, bits [1:0] ignored):
//   0x0 LED      RW  [LED_W-1:0]
//   0x4 KEY      RO  debounced level (writes ignored)
//   0x8 IRQ_EN   RW  per-key interrupt enable
//   0xC IRQ_STAT W1C sticky press flags (a new press wins over a clear)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus_req    one-cycle access request
//   bus_we     1 = write, 0 = read (qualified by bus_req)
//   bus_addr   byte address [3:0]
//   bus_wdata  write data
//   bus_rdata  read data, valid during bus_ack, else 0
//   bus_ack    one-cycle acknowledge, cycle after bus_req
//   key        raw keys, active-low, idle 1
//   led        LED drive (LED register value)
//   irq        level interrupt, |(IRQ_STAT & IRQ_EN), registered
module sopc_gpio #(
  parameter int KEY_W      = 4,
  parameter int LED_W      = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [3:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  input  logic [KEY_W-1:0] key,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  logic [LED_W-1:0] led_q, led_d;
  logic [KEY_W-1:0] en_q, en_d;
  logic [KEY_W-1:0] stat_q, stat_d;
  logic             irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;

  logic [KEY_W-1:0] key_lvl;   // level visible in the KEY register
  logic [KEY_W-1:0] press;     // 1->0 transition of key_lvl at this edge
  logic [KEY_W-1:0] w1c;
  logic [1:0]       sel;

  // Low address bits and unused write-data bits are don't-care.
  logic unused_bus;
  assign unused_bus = ^{bus_addr[1:0], bus_wdata};

  assign sel = bus_addr[3:2];

  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
  end

`ifdef SOPC_GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

  logic [KEY_W-1:0]            deb_q, deb_d;
  logic [KEY_W-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the sample disagrees with the debounced state;
  // any agreement restarts the count, so only a stable change gets through.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < KEY_W; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign key_lvl = deb_q;
  assign press   = deb_q & ~deb_d;
`else
  logic [31:0] unused_deb;
  assign unused_deb = 32'(DEB_CYCLES);

  assign key_lvl = sync2_q;
  assign press   = sync2_q & ~sync2_d;
`endif

  always_comb begin
    led_d   = led_q;
    en_d    = en_q;
    w1c     = '0;
    ack_d   = bus_req;
    rdata_d = '0;
    if (bus_req && bus_we) begin
      case (sel)
        2'd0:    led_d = bus_wdata[LED_W-1:0];
        2'd2:    en_d  = bus_wdata[KEY_W-1:0];
        2'd3:    w1c   = bus_wdata[KEY_W-1:0];
        default: ;
      endcase
    end
    if (bus_req && !bus_we) begin
      case (sel)
        2'd0:    rdata_d = 32'(led_q);
        2'd1:    rdata_d = 32'(key_lvl);
        2'd2:    rdata_d = 32'(en_q);
        default: rdata_d = 32'(stat_q);
      endcase
    end
    // Set has priority over clear so a press coinciding with a clear is kept.
    stat_d = (stat_q & ~w1c) | press;
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      en_q    <= '0;
      stat_q  <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      led_q   <= led_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign led       = led_q;
  assign irq       = irq_q;
  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;

endmodule
